// File: rtl/sync_fifo_ctr.sv
// Single-clock FIFO with exact fill count, programmable almost flags and FWFT/registered read.
// Optional sticky overflow/underflow outputs when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ctr #(
    parameter int unsigned data_width         = 8,
    parameter int unsigned depth_width        = 5,
    parameter int unsigned almost_full_level  = (1 << depth_width) - 2,
    parameter int unsigned almost_empty_level = 2,
    parameter int unsigned fwft               = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [data_width-1:0]  wr_data,
    input  logic                   rd_en,
    output logic [data_width-1:0]  rd_data,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [depth_width:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int unsigned depth = 1 << depth_width;
    localparam logic [depth_width:0] depth_cnt = (depth_width + 1)'(depth);
    localparam logic [depth_width:0] af_lvl    = (depth_width + 1)'(almost_full_level);
    localparam logic [depth_width:0] ae_lvl    = (depth_width + 1)'(almost_empty_level);

    logic [data_width-1:0]  mem [depth];
    logic [depth_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth_width:0]   count_q, count_d;
    logic                   wr_acc, rd_acc;

    always_comb begin
        full         = (count_q == depth_cnt);
        empty        = (count_q == '0);
        almost_full  = (count_q >= af_lvl);
        almost_empty = (count_q <= ae_lvl);
        count        = count_q;
    end

    // A full FIFO still accepts a write when a pop frees a slot on the same edge.
    always_comb begin
        rd_acc = rd_en && !empty;
        wr_acc = wr_en && (!full || rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; only the pointers and count are.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    if (fwft != 0) begin : g_fwft
        // Head word shown directly; forced to zero while nothing is stored.
        always_comb begin
            rd_data = empty ? '0 : mem[rd_ptr_q];
        end
    end else begin : g_reg_read
        logic [data_width-1:0] rd_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end

        always_comb begin
            rd_data = rd_data_q;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) overflow_q  <= 1'b1;
            if (rd_en && empty)   underflow_q <= 1'b1;
        end
    end

    always_comb begin
        overflow  = overflow_q;
        underflow = underflow_q;
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctr.sv
// Drives a registered-read and an FWFT instance (depth 4) with identical stimulus
// and compares both against a queue-based reference model.
module tb_sync_fifo_ctr;

    logic       clk = 1'b0;
    logic       reset, wr_en, rd_en;
    logic [7:0] wr_data;

    logic [7:0] r_data, f_data;
    logic       r_full, r_empty, r_af, r_ae, f_full, f_empty, f_af, f_ae;
    logic [2:0] r_count, f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       r_ovf, r_unf, f_ovf, f_unf;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic [7:0] exp_reg;
    logic       exp_ovf, exp_unf;

    always #5 clk = ~clk;

    sync_fifo_ctr #(.data_width(8), .depth_width(2), .fwft(0)) u_reg (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(r_data), .full(r_full), .empty(r_empty), .almost_full(r_af),
        .almost_empty(r_ae), .count(r_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(r_ovf), .underflow(r_unf)
`endif
    );

    sync_fifo_ctr #(.data_width(8), .depth_width(2), .fwft(1)) u_fw (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_data), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(f_ovf), .underflow(f_unf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("reg_count", 32'(r_count), n);
        chk("reg_empty", 32'(r_empty), 32'(n == 0));
        chk("reg_full", 32'(r_full), 32'(n == 4));
        chk("reg_almost_full", 32'(r_af), 32'(n >= 2));
        chk("reg_almost_empty", 32'(r_ae), 32'(n <= 2));
        chk("reg_rd_data", 32'(r_data), 32'(exp_reg));
        chk("fw_count", 32'(f_count), n);
        chk("fw_empty", 32'(f_empty), 32'(n == 0));
        chk("fw_full", 32'(f_full), 32'(n == 4));
        if (n != 0) chk("fw_rd_data", 32'(f_data), 32'(q[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("reg_overflow", 32'(r_ovf), 32'(exp_ovf));
        chk("reg_underflow", 32'(r_unf), 32'(exp_unf));
        chk("fw_overflow", 32'(f_ovf), 32'(exp_ovf));
        chk("fw_underflow", 32'(f_unf), 32'(exp_unf));
`endif
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, then check.
    task automatic step(input logic rs, input logic we, input logic [7:0] wd, input logic re);
        int  n;
        bit  racc, wacc;
        reset = rs; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        if (rs) begin
            q.delete();
            exp_reg = 8'h00;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            n    = q.size();
            racc = re && (n != 0);
            wacc = we && ((n < 4) || racc);
            if (we && !wacc) exp_ovf = 1'b1;
            if (re && n == 0) exp_unf = 1'b1;
            if (racc) exp_reg = q.pop_front();
            if (wacc) q.push_back(wd);
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        exp_reg = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;

        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1);  // reset wins over wr_en/rd_en
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill, drop a write while full, drain in order, then read on empty.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, vals[i], 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Simultaneous write and pop while full.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, vals[i], 1'b0);
        step(1'b0, 1'b1, 8'h66, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Fall-through of a single word, then pop it.
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Wrap-around with write/read pairs.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Reset mid-operation with three words stored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
